// File: rtl/gp_regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gp_regfile_sb_pkg
// Description : Shared defaults for the GP register file / write scoreboard.
//               Optional same-cycle write-back bypass is selected by the
//               macro DIAD_GPSB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package gp_regfile_sb_pkg;

    localparam int C_GPSB_REG_CNT  = 16;
    localparam int C_GPSB_DATA_W   = 24;
    localparam int C_GPSB_PEND_W   = 2;
    localparam int C_GPSB_RD_PORTS = 2;

    // High-bit indices in the core's usual style
    localparam int HBIT_DATA   = C_GPSB_DATA_W - 1;
    localparam int HBIT_TGT_GP = $clog2(C_GPSB_REG_CNT) - 1;

    // Name of the macro enabling write-back to read bypass
    localparam string C_GPSB_BYPASS_MACRO = "DIAD_GPSB_BYPASS_EN";

    // Largest value a pending counter of the given width can hold
    function automatic int gpsb_pend_max(input int pend_w);
        return (1 << pend_w) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gp_regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : gp_regfile_sb_if
// Description : Read / issue / write-back / flush bundle of the GP register
//               file. master = ID/EX/WB side, slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface gp_regfile_sb_if
    import gp_regfile_sb_pkg::*;
#(
    parameter int DATA_W   = C_GPSB_DATA_W,
    parameter int REG_CNT  = C_GPSB_REG_CNT,
    parameter int RD_PORTS = C_GPSB_RD_PORTS,
    parameter int AW       = $clog2(REG_CNT)
);
    logic [RD_PORTS*AW-1:0]     iw_read_addr;
    logic [RD_PORTS*DATA_W-1:0] ow_read_data;
    logic [RD_PORTS-1:0]        ow_read_busy;
    logic                       iw_issue_valid;
    logic [AW-1:0]              iw_issue_addr;
    logic                       ow_issue_ready;
    logic                       iw_write_enable;
    logic [AW-1:0]              iw_write_addr;
    logic [DATA_W-1:0]          iw_write_data;
    logic                       iw_flush;
    logic                       ow_any_busy;

    modport master (
        output iw_read_addr, iw_issue_valid, iw_issue_addr,
               iw_write_enable, iw_write_addr, iw_write_data, iw_flush,
        input  ow_read_data, ow_read_busy, ow_issue_ready, ow_any_busy
    );

    modport slave (
        input  iw_read_addr, iw_issue_valid, iw_issue_addr,
               iw_write_enable, iw_write_addr, iw_write_data, iw_flush,
        output ow_read_data, ow_read_busy, ow_issue_ready, ow_any_busy
    );
endinterface
`default_nettype wire

// File: rtl/gp_regfile_sb_pend_ctr.sv
`default_nettype none
// ============================================================================
// Module      : gpsb_pend_ctr
// Description : Saturating up/down counter of outstanding writes for one
//               register. Clear has priority; inc and dec together hold.
// Revision    : 1.0 - initial release
// ============================================================================
module gpsb_pend_ctr #(
    parameter int PEND_W = 2
) (
    input  wire logic              iw_clk,
    input  wire logic              iw_rst,
    input  wire logic              iw_inc,
    input  wire logic              iw_dec,
    input  wire logic              iw_clr,
    output logic [PEND_W-1:0]      ow_count,
    output logic                   ow_zero,
    output logic                   ow_full
);
    localparam logic [PEND_W-1:0] C_MAX = {PEND_W{1'b1}};

    logic [PEND_W-1:0] r_count;

    // Count claims up and retires down, never wrapping at either end
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_count <= '0;
        end else if (iw_clr) begin
            r_count <= '0;
        end else if (iw_inc && !iw_dec && (r_count != C_MAX)) begin
            r_count <= r_count + 1'b1;
        end else if (iw_dec && !iw_inc && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign ow_count = r_count;
    assign ow_zero  = (r_count == '0);
    assign ow_full  = (r_count == C_MAX);
endmodule
`default_nettype wire

// File: rtl/gp_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : gp_regfile_sb
// Description : GP register file with per-register pending-write scoreboard.
//               RD_PORTS combinational reads, one issue (claim) port, one
//               write-back port, global flush of outstanding claims.
//               Define DIAD_GPSB_BYPASS_EN to forward write-back data and
//               busy state to same-cycle reads of the target register.
// Revision    : 1.0 - initial release
// ============================================================================
module gp_regfile_sb
    import gp_regfile_sb_pkg::*;
#(
    parameter int DATA_W   = C_GPSB_DATA_W,
    parameter int REG_CNT  = C_GPSB_REG_CNT,
    parameter int RD_PORTS = C_GPSB_RD_PORTS,
    parameter int PEND_W   = C_GPSB_PEND_W
) (
    input  wire logic          iw_clk,
    input  wire logic          iw_rst,
    gp_regfile_sb_if.slave     bus
);
    localparam int AW = $clog2(REG_CNT);

    logic [DATA_W-1:0] r_regs [REG_CNT];
    logic [PEND_W-1:0] w_pend [REG_CNT];
    logic [REG_CNT-1:0] w_zero;
    logic [REG_CNT-1:0] w_full;
    logic [REG_CNT-1:0] w_inc;
    logic [REG_CNT-1:0] w_dec;
    logic               w_claim;

    // A claim is taken only when the target counter has room and no flush
    assign bus.ow_issue_ready = !bus.iw_flush && !w_full[bus.iw_issue_addr];
    assign w_claim            = bus.iw_issue_valid && bus.ow_issue_ready;
    assign bus.ow_any_busy    = ~&w_zero;

    // Write-back updates the data array; claims never touch data
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            for (int i = 0; i < REG_CNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (bus.iw_write_enable) begin
            r_regs[bus.iw_write_addr] <= bus.iw_write_data;
        end
    end

    for (genvar i = 0; i < REG_CNT; i++) begin : g_pend
        assign w_inc[i] = w_claim && (bus.iw_issue_addr == AW'(i));
        assign w_dec[i] = bus.iw_write_enable && (bus.iw_write_addr == AW'(i));

        gpsb_pend_ctr #(
            .PEND_W (PEND_W)
        ) u_ctr (
            .iw_clk   (iw_clk),
            .iw_rst   (iw_rst),
            .iw_inc   (w_inc[i]),
            .iw_dec   (w_dec[i]),
            .iw_clr   (bus.iw_flush),
            .ow_count (w_pend[i]),
            .ow_zero  (w_zero[i]),
            .ow_full  (w_full[i])
        );
    end

    for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
        logic [AW-1:0] w_addr;
        assign w_addr = bus.iw_read_addr[p*AW +: AW];
`ifdef DIAD_GPSB_BYPASS_EN
        localparam logic [PEND_W-1:0] C_ONE = PEND_W'(1);
        logic w_hit;
        // A retiring write to this register is seen now; its own claim no
        // longer counts toward busy
        assign w_hit = bus.iw_write_enable && (bus.iw_write_addr == w_addr);
        assign bus.ow_read_data[p*DATA_W +: DATA_W] =
            w_hit ? bus.iw_write_data : r_regs[w_addr];
        assign bus.ow_read_busy[p] =
            w_hit ? (w_pend[w_addr] > C_ONE) : (w_pend[w_addr] != '0);
`else
        assign bus.ow_read_data[p*DATA_W +: DATA_W] = r_regs[w_addr];
        assign bus.ow_read_busy[p] = (w_pend[w_addr] != '0);
`endif
    end
endmodule
`default_nettype wire

// File: tb/tb_gp_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_regfile_sb
// Description : Self-checking bench for gp_regfile_sb: directed vector table,
//               hand-written bypass and async-reset sequences, and random
//               traffic against a behavioural scoreboard model.
//               Honours DIAD_GPSB_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gp_regfile_sb;

`ifdef DIAD_GPSB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam int PMAX = 3;

    logic iw_clk = 1'b0;
    logic iw_rst = 1'b1;
    always #5 iw_clk = ~iw_clk;

    gp_regfile_sb_if #(.DATA_W(24), .REG_CNT(16), .RD_PORTS(2)) bus ();

    gp_regfile_sb #(
        .DATA_W(24), .REG_CNT(16), .RD_PORTS(2), .PEND_W(2)
    ) dut (
        .iw_clk (iw_clk),
        .iw_rst (iw_rst),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [23:0] m_reg  [16];
    int          m_pend [16];

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [23:0] wd;
        logic        iv;
        logic [3:0]  ia;
        logic        fl;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [23:0] d0;
        logic [23:0] d1;
        logic        b0;
        logic        b1;
        logic        rdy;
        logic        any;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [3:0] wa, input logic [23:0] wd,
                       input logic iv, input logic [3:0] ia, input logic fl,
                       input logic [3:0] ra0, input logic [3:0] ra1,
                       input logic [23:0] d0, input logic [23:0] d1,
                       input logic b0, input logic b1, input logic rdy, input logic any);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ia = ia; v.fl = fl;
        v.ra0 = ra0; v.ra1 = ra1; v.d0 = d0; v.d1 = d1;
        v.b0 = b0; v.b1 = b1; v.rdy = rdy; v.any = any;
        tbl.push_back(v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_reg[i]  = '0;
            m_pend[i] = 0;
        end
    endtask

    // Apply inputs just after the falling edge, settle for 1 time unit
    task automatic drive(input logic we, input logic [3:0] wa, input logic [23:0] wd,
                         input logic iv, input logic [3:0] ia, input logic fl,
                         input logic [3:0] ra0, input logic [3:0] ra1);
        @(negedge iw_clk);
        bus.iw_write_enable = we;
        bus.iw_write_addr   = wa;
        bus.iw_write_data   = wd;
        bus.iw_issue_valid  = iv;
        bus.iw_issue_addr   = ia;
        bus.iw_flush        = fl;
        bus.iw_read_addr    = {ra1, ra0};
        #1;
    endtask

    // Advance the model across the rising edge using the held inputs
    task automatic commit();
        logic claim;
        @(posedge iw_clk);
        claim = bus.iw_issue_valid && !bus.iw_flush && (m_pend[bus.iw_issue_addr] < PMAX);
        if (bus.iw_write_enable) m_reg[bus.iw_write_addr] = bus.iw_write_data;
        if (bus.iw_flush) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 0;
        end else begin
            if (claim) m_pend[bus.iw_issue_addr]++;
            if (bus.iw_write_enable && m_pend[bus.iw_write_addr] > 0)
                m_pend[bus.iw_write_addr]--;
        end
    endtask

    function automatic logic bypass_hit(input logic [3:0] ra);
        return BYP && bus.iw_write_enable && (bus.iw_write_addr == ra);
    endfunction

    function automatic logic [23:0] exp_data(input logic [3:0] ra);
        return bypass_hit(ra) ? bus.iw_write_data : m_reg[ra];
    endfunction

    function automatic logic exp_busy(input logic [3:0] ra);
        return bypass_hit(ra) ? (m_pend[ra] > 1) : (m_pend[ra] != 0);
    endfunction

    function automatic logic exp_any();
        logic a = 1'b0;
        for (int i = 0; i < 16; i++) if (m_pend[i] != 0) a = 1'b1;
        return a;
    endfunction

    function automatic logic [3:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
    endfunction

    initial begin
        bus.iw_write_enable = 1'b0;
        bus.iw_write_addr   = '0;
        bus.iw_write_data   = '0;
        bus.iw_issue_valid  = 1'b0;
        bus.iw_issue_addr   = '0;
        bus.iw_flush        = 1'b0;
        bus.iw_read_addr    = '0;
        model_reset();

        // Outputs while reset is held
        #2;
        chk("rst_any", 32'(bus.ow_any_busy), 32'd0);
        chk("rst_rdy", 32'(bus.ow_issue_ready), 32'd1);
        repeat (2) @(posedge iw_clk);
        @(negedge iw_clk);
        iw_rst = 1'b0;

        // Every address on both ports reads 0 / not busy after reset
        for (int a = 0; a < 16; a++) begin
            drive(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 1'b0, 4'(a), 4'(15 - a));
            chk("init_d0", 32'(bus.ow_read_data[23:0]), 32'd0);
            chk("init_d1", 32'(bus.ow_read_data[47:24]), 32'd0);
            chk("init_busy", 32'(bus.ow_read_busy), 32'd0);
            chk("init_rdy", 32'(bus.ow_issue_ready), 32'd1);
            chk("init_any", 32'(bus.ow_any_busy), 32'd0);
            commit();
        end

        //   we  wa    wd           iv  ia    fl  ra0   ra1   d0           d1           b0 b1 rdy any
        add(0, 4'd0,  24'h000000, 0, 4'd0, 0, 4'd0, 4'd15, 24'h000000, 24'h000000, 0, 0, 1, 0);
        add(1, 4'd5,  24'h123456, 0, 4'd0, 0, 4'd4, 4'd6,  24'h000000, 24'h000000, 0, 0, 1, 0);
        add(0, 4'd0,  24'h000000, 0, 4'd0, 0, 4'd5, 4'd5,  24'h123456, 24'h123456, 0, 0, 1, 0);
        add(0, 4'd0,  24'h000000, 1, 4'd3, 0, 4'd3, 4'd5,  24'h000000, 24'h123456, 0, 0, 1, 0);
        add(0, 4'd0,  24'h000000, 1, 4'd3, 0, 4'd3, 4'd5,  24'h000000, 24'h123456, 1, 0, 1, 1);
        add(0, 4'd0,  24'h000000, 1, 4'd3, 0, 4'd3, 4'd5,  24'h000000, 24'h123456, 1, 0, 1, 1);
        add(0, 4'd0,  24'h000000, 1, 4'd3, 0, 4'd3, 4'd5,  24'h000000, 24'h123456, 1, 0, 0, 1);
        add(1, 4'd3,  24'h00AAAA, 1, 4'd3, 0, 4'd5, 4'd2,  24'h123456, 24'h000000, 0, 0, 0, 1);
        add(0, 4'd0,  24'h000000, 0, 4'd3, 0, 4'd3, 4'd3,  24'h00AAAA, 24'h00AAAA, 1, 1, 1, 1);
        add(1, 4'd3,  24'h000001, 0, 4'd3, 0, 4'd5, 4'd5,  24'h123456, 24'h123456, 0, 0, 1, 1);
        add(1, 4'd3,  24'h000002, 0, 4'd3, 0, 4'd5, 4'd5,  24'h123456, 24'h123456, 0, 0, 1, 1);
        add(0, 4'd0,  24'h000000, 0, 4'd0, 0, 4'd3, 4'd7,  24'h000002, 24'h000000, 0, 0, 1, 0);
        add(0, 4'd0,  24'h000000, 1, 4'd7, 0, 4'd7, 4'd3,  24'h000000, 24'h000002, 0, 0, 1, 0);
        add(1, 4'd7,  24'h777777, 1, 4'd7, 0, 4'd6, 4'd3,  24'h000000, 24'h000002, 0, 0, 1, 1);
        add(0, 4'd0,  24'h000000, 0, 4'd7, 0, 4'd7, 4'd7,  24'h777777, 24'h777777, 1, 1, 1, 1);
        add(1, 4'd7,  24'h000000, 0, 4'd0, 0, 4'd0, 4'd1,  24'h000000, 24'h000000, 0, 0, 1, 1);
        add(0, 4'd0,  24'h000000, 1, 4'd2, 0, 4'd2, 4'd4,  24'h000000, 24'h000000, 0, 0, 1, 0);
        add(0, 4'd0,  24'h000000, 1, 4'd4, 0, 4'd2, 4'd4,  24'h000000, 24'h000000, 1, 0, 1, 1);
        add(0, 4'd0,  24'h000000, 1, 4'd9, 0, 4'd9, 4'd2,  24'h000000, 24'h000000, 0, 1, 1, 1);
        add(1, 4'd4,  24'hABCDEF, 1, 4'd5, 1, 4'd9, 4'd2,  24'h000000, 24'h000000, 1, 1, 0, 1);
        add(0, 4'd0,  24'h000000, 0, 4'd5, 0, 4'd4, 4'd5,  24'hABCDEF, 24'h123456, 0, 0, 1, 0);
        add(0, 4'd0,  24'h000000, 0, 4'd0, 0, 4'd2, 4'd9,  24'h000000, 24'h000000, 0, 0, 1, 0);
        add(1, 4'd1,  24'h111111, 0, 4'd0, 0, 4'd0, 4'd5,  24'h000000, 24'h123456, 0, 0, 1, 0);
        add(0, 4'd0,  24'h000000, 0, 4'd0, 0, 4'd1, 4'd1,  24'h111111, 24'h111111, 0, 0, 1, 0);

        foreach (tbl[k]) begin
            drive(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].iv, tbl[k].ia, tbl[k].fl,
                  tbl[k].ra0, tbl[k].ra1);
            chk($sformatf("tbl%0d_d0", k), 32'(bus.ow_read_data[23:0]), 32'(tbl[k].d0));
            chk($sformatf("tbl%0d_d1", k), 32'(bus.ow_read_data[47:24]), 32'(tbl[k].d1));
            chk($sformatf("tbl%0d_b0", k), 32'(bus.ow_read_busy[0]), 32'(tbl[k].b0));
            chk($sformatf("tbl%0d_b1", k), 32'(bus.ow_read_busy[1]), 32'(tbl[k].b1));
            chk($sformatf("tbl%0d_rdy", k), 32'(bus.ow_issue_ready), 32'(tbl[k].rdy));
            chk($sformatf("tbl%0d_any", k), 32'(bus.ow_any_busy), 32'(tbl[k].any));
            commit();
        end

        // Same-cycle read of a retiring register (bypass-dependent)
        drive(1'b0, 4'd0, 24'd0, 1'b1, 4'd10, 1'b0, 4'd10, 4'd0);
        commit();
        drive(1'b1, 4'd10, 24'h5A5A5A, 1'b0, 4'd0, 1'b0, 4'd10, 4'd0);
        chk("byp_d0", 32'(bus.ow_read_data[23:0]), BYP ? 32'h5A5A5A : 32'h0);
        chk("byp_b0", 32'(bus.ow_read_busy[0]), BYP ? 32'd0 : 32'd1);
        commit();
        drive(1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 1'b0, 4'd10, 4'd0);
        chk("byp_next_d0", 32'(bus.ow_read_data[23:0]), 32'h5A5A5A);
        chk("byp_next_b0", 32'(bus.ow_read_busy[0]), 32'd0);
        commit();

        // Asynchronous reset in the middle of a cycle
        drive(1'b0, 4'd0, 24'd0, 1'b1, 4'd1, 1'b0, 4'd1, 4'd1);
        commit();
        drive(1'b0, 4'd0, 24'd0, 1'b0, 4'd1, 1'b0, 4'd1, 4'd1);
        chk("arst_pre_d0", 32'(bus.ow_read_data[23:0]), 32'h111111);
        chk("arst_pre_b0", 32'(bus.ow_read_busy[0]), 32'd1);
        chk("arst_pre_any", 32'(bus.ow_any_busy), 32'd1);
        #2;
        iw_rst = 1'b1;
        #1;
        chk("arst_d0", 32'(bus.ow_read_data[23:0]), 32'd0);
        chk("arst_busy", 32'(bus.ow_read_busy), 32'd0);
        chk("arst_any", 32'(bus.ow_any_busy), 32'd0);
        chk("arst_rdy", 32'(bus.ow_issue_ready), 32'd1);
        @(posedge iw_clk);
        @(negedge iw_clk);
        iw_rst = 1'b0;
        model_reset();

        // Random traffic against the scoreboard model
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), rnd_addr(), 24'($urandom),
                  1'($urandom_range(0, 1)), rnd_addr(),
                  ($urandom_range(0, 15) == 0), rnd_addr(), rnd_addr());
            chk("rnd_d0", 32'(bus.ow_read_data[23:0]), 32'(exp_data(bus.iw_read_addr[3:0])));
            chk("rnd_d1", 32'(bus.ow_read_data[47:24]), 32'(exp_data(bus.iw_read_addr[7:4])));
            chk("rnd_b0", 32'(bus.ow_read_busy[0]), 32'(exp_busy(bus.iw_read_addr[3:0])));
            chk("rnd_b1", 32'(bus.ow_read_busy[1]), 32'(exp_busy(bus.iw_read_addr[7:4])));
            chk("rnd_rdy", 32'(bus.ow_issue_ready),
                32'(!bus.iw_flush && (m_pend[bus.iw_issue_addr] < PMAX)));
            chk("rnd_any", 32'(bus.ow_any_busy), 32'(exp_any()));
            commit();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gp_regfile_sb.md
# gp_regfile_sb

Parametrised general-purpose register file with an integrated write scoreboard, the next generation of the core's GP register bank. It provides RD_PORTS combinational read ports, one write-back port and one issue (claim) port. A per-register saturating pending-write counter lets the decode/execute stages detect RAW hazards and stall. It sits between the ID/EX stages (reads, claims) and the WB stage (retire writes).

## Interface
- DATA_W, 24, register data width
- REG_CNT, 16, number of registers; power of two, ≥2
- RD_PORTS, 2, number of read ports, 1..4
- PEND_W, 2, pending-counter width; max outstanding writes per register = 2^PEND_W-1
- Address width AW = clog2(REG_CNT)

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  reset, asynchronous, active-high
- iw_read_addr  in  RD_PORTS*AW  packed read addresses, port p at bits [p*AW +: AW]
- ow_read_data  out  RD_PORTS*DATA_W  packed read data
- ow_read_busy  out  RD_PORTS  port p's register has an outstanding write
- iw_issue_valid  in  1  claim a pending write on iw_issue_addr
- iw_issue_addr  in  AW  register being claimed
- ow_issue_ready  out  1  claim accepted this cycle
- iw_write_enable  in  1  WB retire
- iw_write_addr  in  AW  WB target
- iw_write_data  in  DATA_W  WB data
- iw_flush  in  1  discard all outstanding claims
- ow_any_busy  out  1  OR of all pending counters non-zero

## Operation
- Storage: REG_CNT × DATA_W registers plus REG_CNT × PEND_W counters; all cleared to 0 on reset.
- Read: ow_read_data[p] = reg[iw_read_addr[p]], combinational.
- ow_read_busy[p] = pend[addr] != 0, except for the bypass case under Configuration.
- Issue handshake: ow_issue_ready = !iw_flush && pend[iw_issue_addr] != max.
  - Claim happens when iw_issue_valid && ow_issue_ready.
  - A claim while not ready is dropped. Upstream must hold and retry.
- Retire: when iw_write_enable is high, reg[iw_write_addr] <= iw_write_data on the edge.
  - The counter decrements, saturating at 0. A write to an unclaimed register is legal: data is written and the counter stays 0.
- Same-register claim and retire in one cycle: the counter is unchanged.
- Different-register claim and retire: each counter updates independently.
- Claim at max with a simultaneous retire on the same register: ow_issue_ready is still 0, so the claim is dropped and the counter decrements.
- Flush: all counters go to 0 on the edge.
  - A simultaneous retire still writes its data.
  - A simultaneous issue is refused (ready is 0).
- Reset mid-operation clears data and counters immediately and asynchronously. Outputs then read 0, busy 0, ready 1.

## Timing
- Reads: 0-cycle latency.
- Write data and counter changes become visible the cycle after the edge, unless bypass applies.
- ow_issue_ready, ow_read_busy and ow_any_busy are combinational from current state and inputs. No registered outputs.
- Outputs during and after reset: ow_read_data = 0, ow_read_busy = 0, ow_any_busy = 0, ow_issue_ready = 1 (while iw_flush = 0).

## Configuration
- Macro: DIAD_GPSB_BYPASS_EN.
- Defined: when iw_write_enable is high and iw_write_addr == iw_read_addr[p]:
  - ow_read_data[p] = iw_write_data in the same cycle.
  - ow_read_busy[p] = (pend[addr] > 1).
- Not defined: reads return stored values only, and busy is pend != 0. A WB-to-read dependency then costs one extra cycle.

## Structure
- Shared package/include holds the defaults, for GP register count, data width and pending width (HBIT_DATA, HBIT_TGT_GP style), and the bypass macro name.
- One sub-module, gpsb_pend_ctr: PEND_W saturating up/down counter.
  - Inputs: inc, dec, clr.
  - Outputs: count, zero, full.
  - Instantiated REG_CNT times in a generate loop.

## Test plan
- Reset, then read all addresses on both ports -> data 0, busy 0, ow_issue_ready 1, ow_any_busy 0.
- Write 0x123456 to r5, read r5 next cycle -> 0x123456, busy 0.
  - With the bypass macro: the same-cycle read also returns 0x123456.
- Claim r3 three times (PEND_W=2) -> ready 1,1,1, then 0 on the fourth attempt.
  - Retire r3 once -> ready 1, busy still 1.
  - After three retires -> busy 0.
- Same-cycle claim and retire on r7 with pend = 1 -> pend stays 1, data updated, busy 1.
- Claim r2, r4, r9; assert iw_flush together with a retire of 0xABCDEF to r4 -> all busy 0, ow_any_busy 0, r4 = 0xABCDEF, an issue in the flush cycle is refused.
- Retire to unclaimed r1 -> data written, counter stays 0.
  - Assert iw_rst asynchronously mid-cycle -> r1 reads 0 and busy 0 before the next edge.
